// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - decode-side hazard descriptors in, stall and forward selects out
interface hazard_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       D_Rs;
    logic [4:0]       D_Rt;
    logic             D_isRead_Rs;
    logic             D_isRead_Rt;
    logic [1:0]       D_Tuse_Rs;
    logic [1:0]       D_Tuse_Rt;
    logic             D_isWrite;
    logic [4:0]       D_WriteDes;
    logic [1:0]       D_Tnew;

    logic             stall;
    logic [1:0]       Fwd_D_Rs;
    logic [1:0]       Fwd_D_Rt;
    logic [1:0]       Fwd_E_Rs;
    logic [1:0]       Fwd_E_Rt;
    logic             Fwd_M_Rt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output D_Rs, D_Rt, D_isRead_Rs, D_isRead_Rt, D_Tuse_Rs, D_Tuse_Rt,
               D_isWrite, D_WriteDes, D_Tnew,
        input  stall, Fwd_D_Rs, Fwd_D_Rt, Fwd_E_Rs, Fwd_E_Rt, Fwd_M_Rt, stall_cnt
    );

    modport slave (
        input  D_Rs, D_Rt, D_isRead_Rs, D_isRead_Rt, D_Tuse_Rs, D_Tuse_Rt,
               D_isWrite, D_WriteDes, D_Tnew,
        output stall, Fwd_D_Rs, Fwd_D_Rt, Fwd_E_Rs, Fwd_E_Rt, Fwd_M_Rt, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - Tuse/Tnew stall and forwarding control for a five-stage pipeline
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
);

    typedef struct packed {
        logic       is_write;
        logic [4:0] des;
        logic [1:0] tnew;
    } wr_t;

    // Shadow writer records; only the reader fields that feed a forward select are kept.
    wr_t              e_wr_q, e_wr_d;
    wr_t              m_wr_q, m_wr_d;
    wr_t              w_wr_q, w_wr_d;
    logic [4:0]       e_rs_q, e_rs_d;
    logic [4:0]       e_rt_q, e_rt_d;
    logic [4:0]       m_rt_q, m_rt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stall_rs;
    logic stall_rt;
    logic stall;

    function automatic wr_t age(input wr_t r);
        wr_t a;
        a = r;
        if (r.tnew != 2'd0) begin
            a.tnew = r.tnew - 2'd1;
        end
        return a;
    endfunction

    function automatic logic busy(input wr_t r, input logic [4:0] reg_a, input logic [1:0] tuse);
        return r.is_write && (r.des == reg_a) && (r.tnew > tuse);
    endfunction

    function automatic logic ready(input wr_t r, input logic [4:0] reg_a);
        return r.is_write && (r.des == reg_a) && (reg_a != 5'd0) && (r.tnew == 2'd0);
    endfunction

    // W always has Tnew 0, so only E and M can hold a value that is not yet produced.
    always_comb begin
        stall_rs = hz.D_isRead_Rs && (hz.D_Rs != 5'd0) &&
                   (busy(e_wr_q, hz.D_Rs, hz.D_Tuse_Rs) || busy(m_wr_q, hz.D_Rs, hz.D_Tuse_Rs));
        stall_rt = hz.D_isRead_Rt && (hz.D_Rt != 5'd0) &&
                   (busy(e_wr_q, hz.D_Rt, hz.D_Tuse_Rt) || busy(m_wr_q, hz.D_Rt, hz.D_Tuse_Rt));
        stall    = stall_rs || stall_rt;
    end

    always_comb begin
        hz.Fwd_D_Rs = 2'b00;
        if (ready(e_wr_q, hz.D_Rs))      hz.Fwd_D_Rs = 2'b01;
        else if (ready(m_wr_q, hz.D_Rs)) hz.Fwd_D_Rs = 2'b10;
        else if (ready(w_wr_q, hz.D_Rs)) hz.Fwd_D_Rs = 2'b11;

        hz.Fwd_D_Rt = 2'b00;
        if (ready(e_wr_q, hz.D_Rt))      hz.Fwd_D_Rt = 2'b01;
        else if (ready(m_wr_q, hz.D_Rt)) hz.Fwd_D_Rt = 2'b10;
        else if (ready(w_wr_q, hz.D_Rt)) hz.Fwd_D_Rt = 2'b11;

        hz.Fwd_E_Rs = 2'b00;
        if (ready(m_wr_q, e_rs_q))       hz.Fwd_E_Rs = 2'b01;
        else if (ready(w_wr_q, e_rs_q))  hz.Fwd_E_Rs = 2'b10;

        hz.Fwd_E_Rt = 2'b00;
        if (ready(m_wr_q, e_rt_q))       hz.Fwd_E_Rt = 2'b01;
        else if (ready(w_wr_q, e_rt_q))  hz.Fwd_E_Rt = 2'b10;

        hz.Fwd_M_Rt = ready(w_wr_q, m_rt_q);
    end

    always_comb begin
        if (stall) begin
            e_wr_d = '0;
            e_rs_d = 5'd0;
            e_rt_d = 5'd0;
        end else begin
            e_wr_d.is_write = hz.D_isWrite;
            e_wr_d.des      = hz.D_WriteDes;
            e_wr_d.tnew     = hz.D_Tnew;
            e_rs_d          = hz.D_Rs;
            e_rt_d          = hz.D_Rt;
        end
        m_wr_d = age(e_wr_q);
        m_rt_d = e_rt_q;
        w_wr_d = age(m_wr_q);
        cnt_d  = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_wr_q <= '0;
            m_wr_q <= '0;
            w_wr_q <= '0;
            e_rs_q <= 5'd0;
            e_rt_q <= 5'd0;
            m_rt_q <= 5'd0;
            cnt_q  <= '0;
        end else begin
            e_wr_q <= e_wr_d;
            m_wr_q <= m_wr_d;
            w_wr_q <= w_wr_d;
            e_rs_q <= e_rs_d;
            e_rt_q <= e_rt_d;
            m_rt_q <= m_rt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hz.stall     = stall;
    assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed instruction-pair vectors against hazard_unit
module tb_hazard_unit;
    localparam int CNT_W = 3;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    hazard_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int rs, input int rt, input int rd_rs, input int rd_rt,
                         input int tu_rs, input int tu_rt, input int wr, input int des,
                         input int tn);
        hz.D_Rs        = rs[4:0];
        hz.D_Rt        = rt[4:0];
        hz.D_isRead_Rs = rd_rs[0];
        hz.D_isRead_Rt = rd_rt[0];
        hz.D_Tuse_Rs   = tu_rs[1:0];
        hz.D_Tuse_Rt   = tu_rt[1:0];
        hz.D_isWrite   = wr[0];
        hz.D_WriteDes  = des[4:0];
        hz.D_Tnew      = tn[1:0];
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
    endtask

    task automatic check_all_fwd_zero(input string tag);
        check({tag, "_fdrs"}, int'(hz.Fwd_D_Rs), 0);
        check({tag, "_fdrt"}, int'(hz.Fwd_D_Rt), 0);
        check({tag, "_fers"}, int'(hz.Fwd_E_Rs), 0);
        check({tag, "_fert"}, int'(hz.Fwd_E_Rt), 0);
        check({tag, "_fmrt"}, int'(hz.Fwd_M_Rt), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        idle();
        #2;
        check("rst_stall", int'(hz.stall), 0);
        check("rst_cnt", int'(hz.stall_cnt), 0);
        check_all_fwd_zero("rst");
        @(posedge clk);
        #2;
        reset = 1'b0;

        // lw $1 ; add $2,$1,$1
        do_reset();
        drive(6, 0, 1, 0, 1, 0, 1, 1, 2);
        check("lwadd_lw_nostall", int'(hz.stall), 0);
        tick();
        drive(1, 1, 1, 1, 1, 1, 1, 2, 1);
        check("lwadd_stall1", int'(hz.stall), 1);
        tick();
        check("lwadd_stall2", int'(hz.stall), 0);
        check("lwadd_fdrs", int'(hz.Fwd_D_Rs), 0);
        tick();
        idle();
        check("lwadd_fers", int'(hz.Fwd_E_Rs), 2);
        check("lwadd_fert", int'(hz.Fwd_E_Rt), 2);
        check("lwadd_cnt", int'(hz.stall_cnt), 1);

        // lw $1 ; beq $1,$0
        do_reset();
        drive(6, 0, 1, 0, 1, 0, 1, 1, 2);
        tick();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
        check("lwbeq_stall1", int'(hz.stall), 1);
        tick();
        check("lwbeq_stall2", int'(hz.stall), 1);
        tick();
        check("lwbeq_stall3", int'(hz.stall), 0);
        check("lwbeq_fdrs", int'(hz.Fwd_D_Rs), 3);
        check("lwbeq_fdrt_zero", int'(hz.Fwd_D_Rt), 0);
        check("lwbeq_cnt", int'(hz.stall_cnt), 2);

        // add $3 ; beq $3,$3
        do_reset();
        drive(1, 2, 1, 1, 1, 1, 1, 3, 1);
        tick();
        drive(3, 3, 1, 1, 0, 0, 0, 0, 0);
        check("addbeq_stall1", int'(hz.stall), 1);
        tick();
        check("addbeq_stall2", int'(hz.stall), 0);
        check("addbeq_fdrs", int'(hz.Fwd_D_Rs), 2);
        check("addbeq_fdrt", int'(hz.Fwd_D_Rt), 2);

        // jal ; jr $31
        do_reset();
        drive(0, 0, 0, 0, 0, 0, 1, 31, 0);
        tick();
        drive(31, 0, 1, 0, 0, 0, 0, 0, 0);
        check("jaljr_stall", int'(hz.stall), 0);
        check("jaljr_fdrs", int'(hz.Fwd_D_Rs), 1);

        // ori $0,$0,5 ; add $4,$0,$0
        do_reset();
        drive(0, 0, 1, 0, 1, 0, 1, 0, 1);
        tick();
        drive(0, 0, 1, 1, 1, 1, 1, 4, 1);
        check("zero_stall", int'(hz.stall), 0);
        check_all_fwd_zero("zero_d");
        tick();
        idle();
        check_all_fwd_zero("zero_e");

        // lw $5 ; sw $5,0($6)
        do_reset();
        drive(0, 0, 1, 0, 1, 0, 1, 5, 2);
        tick();
        drive(6, 5, 1, 1, 1, 2, 0, 0, 0);
        check("lwsw_stall", int'(hz.stall), 0);
        check("lwsw_fdrt", int'(hz.Fwd_D_Rt), 0);
        tick();
        idle();
        check("lwsw_fert", int'(hz.Fwd_E_Rt), 0);
        tick();
        check("lwsw_fmrt", int'(hz.Fwd_M_Rt), 1);

        // four lw/beq pairs: eight stalls against a 3-bit counter
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(6, 0, 1, 0, 1, 0, 1, 1, 2);
            tick();
            drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
            tick();
            tick();
            tick();
            if (i == 2) check("sat_cnt6", int'(hz.stall_cnt), 6);
        end
        check("sat_cnt_max", int'(hz.stall_cnt), 7);

        // reset while stalled
        do_reset();
        drive(6, 0, 1, 0, 1, 0, 1, 1, 2);
        tick();
        drive(1, 0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        check("rmid_pre_stall", int'(hz.stall), 1);
        check("rmid_pre_cnt", int'(hz.stall_cnt), 1);
        reset = 1'b1;
        #1;
        check("rmid_stall", int'(hz.stall), 0);
        check("rmid_cnt", int'(hz.stall_cnt), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rmid_post_stall", int'(hz.stall), 0);
        check_all_fwd_zero("rmid_post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumes the per-instruction hazard descriptors the decode controller emits: Tuse, Tnew, read/write flags and write destination.
- Tracks the in-flight writers in E, M and W with internal shadow pipeline registers, ageing Tnew each cycle.
- Issues the D-stage stall/bubble request and the forwarding mux selects for the D, E and M stages.
- Sits beside the five-stage datapath and is the single owner of the stall and forward decisions.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- D_Rs  in  5  rs field of the instruction in D.
- D_Rt  in  5  rt field of the instruction in D.
- D_isRead_Rs  in  1  D instruction reads rs.
- D_isRead_Rt  in  1  D instruction reads rt.
- D_Tuse_Rs  in  2  D-stage Tuse for rs.
- D_Tuse_Rt  in  2  D-stage Tuse for rt.
- D_isWrite  in  1  D instruction writes the GRF.
- D_WriteDes  in  5  GRF destination of the D instruction.
- D_Tnew  in  2  Tnew the D instruction will have on entering E (load 2, cal 1, link 0).
- stall  out  1  holds PC/IF-ID and injects a bubble into E (combinational).
- Fwd_D_Rs  out  2  D rs select: 00 GRF, 01 E, 10 M, 11 W.
- Fwd_D_Rt  out  2  D rt select, same encoding as Fwd_D_Rs.
- Fwd_E_Rs  out  2  E rs select: 00 register, 01 M, 10 W.
- Fwd_E_Rt  out  2  E rt select, same encoding as Fwd_E_Rs.
- Fwd_M_Rt  out  1  M rt (store data) select: 0 register, 1 W.
- stall_cnt  out  CNT_W  number of stall cycles since reset.

Behaviour:
- Internal records: E, M and W each hold {isWrite, WriteDes, Tnew}. E and M additionally hold the reader fields {Rs, Rt, isRead_Rs, isRead_Rt}.
- Reset (asynchronous, immediate): all records cleared (isWrite=0, fields 0), stall_cnt=0. With empty records, stall=0 and every Fwd output is 0.
- Stall (combinational) for rs:
  - D_isRead_Rs && D_Rs!=0, and
  - for stage X in {E, M}: X.isWrite && X.WriteDes==D_Rs && X.Tnew > D_Tuse_Rs.
- Stall for rt: the same test using D_Rt and D_Tuse_Rt.
- stall = rs stall OR rt stall. The W stage never causes a stall (its Tnew is always 0).
- Clock edge, stall=0: E <= D inputs; M <= E with Tnew-1 saturating at 0; W <= M with Tnew-1 saturating at 0.
- Clock edge, stall=1: E <= bubble (all fields 0); M and W advance as above; D inputs are held by the datapath.
- stall_cnt increments on each edge where stall=1; it saturates at all-ones and does not wrap.
- Forward match at stage X for register r: X.isWrite && X.WriteDes==r && r!=0 && X.Tnew==0.
- Forward priority is nearest stage first:
  - D: E > M > W > GRF.
  - E: M > W > register.
  - M rt: W > register.
- Forwarding does not depend on isRead; an unused select is harmless.
- Forward selects are purely combinational from the current records and D inputs; there is no extra latency.
- Writes to $0: never cause a stall, never produce a forward.
- Simultaneous rs and rt hazards on different stages: a single stall. Forwarding for each operand is resolved independently.
- Reset asserted mid-stall: stall drops to 0 in the same cycle, and all records are empty on release.

Test Plan:
- lw $1 then add $2,$1,$1:
  - cycle 1: stall=1 (E.Tnew 2 > Tuse 1).
  - cycle 2: stall=0.
  - add in E with lw in W: Fwd_E_Rs=Fwd_E_Rt=10.
  - stall_cnt=1.
- lw $1 then beq $1,$0:
  - stall=1 for two cycles (Tnew 2, then 1, both > 0).
  - third cycle: stall=0 and Fwd_D_Rs=11.
  - stall_cnt=2.
- add $3 then beq $3,$3:
  - one stall cycle.
  - then Fwd_D_Rs=Fwd_D_Rt=10 (M, Tnew 0).
- jal then jr $31: stall=0, Fwd_D_Rs=01 (E record, Tnew 0).
- ori $0,$0,5 then add $4,$0,$0: stall=0, all Fwd=0.
- lw $5 then sw $5,0($6) reaching M with lw in W: Fwd_M_Rt=1, no stall (sw Tuse_Rt 2 ≥ Tnew).
- reset pulse while stall=1: stall=0 and stall_cnt=0 in the same cycle, Fwd all 0 afterwards.
